// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared state encoding and sizing helpers for the Booth multiplier arbiter.
package booth_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_BUSY  = 3'd3,
    S_RESP  = 3'd4
  } arb_state_e;

  // A Booth multiply of n bits finishes in about n steps, so 4n+8 leaves generous headroom.
  function automatic int wdog_default(input int n);
    return 4 * n + 8;
  endfunction

  // Requester index width; a single requester still needs one bit of index.
  function automatic int idw_of(input int r);
    return (r > 2) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/booth_rr_pick.sv
// booth_rr_pick: combinational round-robin picker.
// The search starts just above ptr and wraps, so the last winner has the lowest priority.
module booth_rr_pick
  import booth_arb_pkg::*;
#(
  parameter int R = 4,
  localparam int IDW = idw_of(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // The lowest request overall is the wrap-around fallback; the lowest one above ptr overrides it.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = R - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDW'(i);
      end
    end
    for (int i = R - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(ptr))) begin
        idx = IDW'(i);
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sequencer that shares one Booth multiplier among R requesters.
// It captures the operands, pulses start, waits for done and returns the tagged product.
// Define BOOTH_ARB_WDOG_EN to build a watchdog that aborts a hung multiply with rsp_err.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int R           = 4,
  parameter int WDOG_CYCLES = wdog_default(N),
  localparam int IDW        = idw_of(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*N-1:0]   req_m,
  input  logic [R*N-1:0]   req_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [2*N-1:0]   rsp_data,
  output logic             rsp_err,
  output logic             mul_start,
  output logic [N-1:0]     mul_m,
  output logic [N-1:0]     mul_q,
  input  logic [2*N-1:0]   mul_data,
  input  logic             mul_done
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [2*N-1:0] rsp_data_q, rsp_data_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           mul_start_q, mul_start_d;
  logic [N-1:0]   mul_m_q, mul_m_d;
  logic [N-1:0]   mul_q_q, mul_q_d;

  logic [R-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic [N-1:0]   sel_m, sel_q;
  logic           accept;

`ifdef BOOTH_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0]  wdog_cnt_q, wdog_cnt_d;
  logic           rsp_err_q, rsp_err_d;
`endif

  booth_rr_pick #(.R(R)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Grants are offered only while idle and never while reset is held.
  assign req_ready = (state_q == S_IDLE && !rst && gnt_any) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  // Steer the winning requester's operand slices toward the capture registers.
  always_comb begin
    sel_m = '0;
    sel_q = '0;
    for (int i = 0; i < R; i++) begin
      if (gnt[i]) begin
        sel_m = req_m[i*N +: N];
        sel_q = req_q[i*N +: N];
      end
    end
  end

  // Next-state and next-output logic; ARM deliberately ignores mul_done to skip a stale level.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    mul_start_d = 1'b0;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
`ifdef BOOTH_ARB_WDOG_EN
    wdog_cnt_d  = wdog_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mul_m_d     = sel_m;
          mul_q_d     = sel_q;
          rsp_id_d    = gnt_idx;
          ptr_d       = gnt_idx;
          mul_start_d = 1'b1;
          state_d     = S_START;
`ifdef BOOTH_ARB_WDOG_EN
          wdog_cnt_d  = '0;
          rsp_err_d   = 1'b0;
`endif
        end
      end
      S_START: begin
        state_d = S_ARM;
      end
      S_ARM: begin
        state_d = S_BUSY;
`ifdef BOOTH_ARB_WDOG_EN
        wdog_cnt_d = wdog_cnt_q + 1'b1;
`endif
      end
      S_BUSY: begin
        if (mul_done) begin
          rsp_data_d  = mul_data;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
`ifdef BOOTH_ARB_WDOG_EN
        else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
          if (wdog_cnt_q == CW'(WDOG_CYCLES - 1)) begin
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(R - 1);
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      mul_start_q <= 1'b0;
      mul_m_q     <= '0;
      mul_q_q     <= '0;
`ifdef BOOTH_ARB_WDOG_EN
      wdog_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      mul_start_q <= mul_start_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
`ifdef BOOTH_ARB_WDOG_EN
      wdog_cnt_q  <= wdog_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign mul_start = mul_start_q;
  assign mul_m     = mul_m_q;
  assign mul_q     = mul_q_q;
`ifdef BOOTH_ARB_WDOG_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
